// File: rtl/sort_pkg.sv
// Shared definitions for the sort framing slice.
// Holds the default lane count and sample width, the pad constant
// and the helper that sizes a lane-count field.
package sort_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;

  // All-ones pad makes unused lanes sort to the top of the sorter output.
  localparam logic [DW_DEF-1:0] PAD_DEF = {DW_DEF{1'b1}};

  // Width needed to hold a count in the range 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_frame_bank.sv
// One N-lane frame buffer with a lane-write port and a close operation.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_wr_en         write i_data into lane i_lane this cycle
//   i_lane          target lane index
//   i_data          sample to store
//   i_close         with i_wr_en: pad the lanes above i_lane and latch
//                   the frame length i_lane+1
//   o_lanes         packed lanes, lane k at [DW*(k+1)-1 : DW*k]
//   o_count         number of real lanes in the last closed frame
module sort_frame_bank
  import sort_pkg::*;
#(
  parameter int            N   = N_DEF,
  parameter int            DW  = DW_DEF,
  parameter logic [DW-1:0] PAD = {DW{1'b1}},
  parameter int            LW  = $clog2(N),
  parameter int            CW  = cnt_w(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wr_en,
  input  logic [LW-1:0]   i_lane,
  input  logic [DW-1:0]   i_data,
  input  logic            i_close,
  output logic [DW*N-1:0] o_lanes,
  output logic [CW-1:0]   o_count
);

  logic [CW-1:0] r_count;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DW-1:0] r_val;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_val <= '0;
      end else if (i_wr_en) begin
        if (int'(i_lane) == gi) begin
          r_val <= i_data;
        end else if (i_close && (gi > int'(i_lane))) begin
          // Lanes past the closing sample are filled in the same edge.
          r_val <= PAD;
        end
      end
    end

    assign o_lanes[gi*DW +: DW] = r_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_wr_en && i_close) begin
      r_count <= CW'(i_lane) + CW'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sort_frame_collector.sv
// Serial-to-frame collector feeding parallel_sorter.
// Samples arrive over in_valid/in_ready and are packed into N-lane frames
// held in two ping-pong banks; completed frames leave over
// frm_valid/frm_ready in completion order.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   sample stream
//   in_last                     closes the current frame early
//   frm_data                    packed frame, lane k at [DW*(k+1)-1 : DW*k]
//   frm_count                   real (non-pad) lanes in frm_data, 1..N
//   frm_valid/frm_ready         frame handshake
module sort_frame_collector
  import sort_pkg::*;
#(
  parameter int            N   = N_DEF,
  parameter int            DW  = DW_DEF,
  parameter logic [DW-1:0] PAD = {DW{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  output logic [DW*N-1:0]       frm_data,
  output logic [cnt_w(N)-1:0]   frm_count,
  output logic                  frm_valid,
  input  logic                  frm_ready
);

  localparam int LW = $clog2(N);
  localparam int CW = cnt_w(N);

  logic          r_wr_sel;
  logic          r_rd_sel;
  logic [LW-1:0] r_lane;
  logic [1:0]    r_full_cnt;

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_close;
  logic [DW*N-1:0] w_bank_data  [2];
  logic [CW-1:0]   w_bank_count [2];

  // Both handshake outputs depend on registered state only.
  assign in_ready  = (r_full_cnt != 2'd2);
  assign frm_valid = (r_full_cnt != 2'd0);

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = frm_valid && frm_ready;
  assign w_close    = w_in_xfer && ((r_lane == LW'(N - 1)) || in_last);

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    sort_frame_bank #(
      .N   (N),
      .DW  (DW),
      .PAD (PAD),
      .LW  (LW),
      .CW  (CW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr_en (w_in_xfer && (r_wr_sel == 1'(gi))),
      .i_lane  (r_lane),
      .i_data  (in_data),
      .i_close (w_close),
      .o_lanes (w_bank_data[gi]),
      .o_count (w_bank_count[gi])
    );
  end

  assign frm_data  = w_bank_data[r_rd_sel];
  assign frm_count = w_bank_count[r_rd_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_sel <= 1'b0;
      r_lane   <= '0;
    end else if (w_close) begin
      r_wr_sel <= ~r_wr_sel;
      r_lane   <= '0;
    end else if (w_in_xfer) begin
      r_lane   <= r_lane + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_sel <= 1'b0;
    end else if (w_out_xfer) begin
      r_rd_sel <= ~r_rd_sel;
    end
  end

  // A completion cannot occur with both banks full, so the count never
  // exceeds 2; simultaneous close and drain cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full_cnt <= 2'd0;
    end else begin
      case ({w_close, w_out_xfer})
        2'b10:   r_full_cnt <= r_full_cnt + 2'd1;
        2'b01:   r_full_cnt <= r_full_cnt - 2'd1;
        default: r_full_cnt <= r_full_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_frame_collector.sv
module tb_sort_frame_collector;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 3;
  localparam logic [DW-1:0] PAD = 8'hFF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [DW*N-1:0] frm_data;
  logic [CW-1:0]   frm_count;
  logic            frm_valid;
  logic            frm_ready;

  sort_frame_collector #(.N(N), .DW(DW), .PAD(PAD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .frm_data  (frm_data),
    .frm_count (frm_count),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW*N-1:0] data;
    int              cnt;
  } frame_t;

  frame_t        q[$];      // completed frames awaiting drain
  logic [DW-1:0] part[$];   // samples of the frame being assembled

  int total = 0;
  int bad   = 0;
  int n_frames = 0;
  int n_accepted = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    part.delete();
  endtask

  task automatic model_close();
    frame_t f;
    f.data = '0;
    for (int k = 0; k < N; k++) begin
      f.data[k*DW +: DW] = (k < part.size()) ? part[k] : PAD;
    end
    f.cnt = part.size();
    q.push_back(f);
    part.delete();
  endtask

  // One clock: compare outputs with the model, then advance the model by
  // the handshakes the model itself predicts for this edge.
  task automatic step();
    bit exp_v, exp_r, ix, ox;
    exp_v = (q.size() != 0);
    exp_r = (q.size() < 2);
    chk("frm_valid", 64'(frm_valid), 64'(exp_v));
    chk("in_ready", 64'(in_ready), 64'(exp_r));
    if (exp_v) begin
      chk("frm_data", 64'(frm_data), 64'(q[0].data));
      chk("frm_count", 64'(frm_count), 64'(q[0].cnt));
    end
    ix = in_valid && exp_r;
    ox = exp_v && frm_ready;
    @(posedge clk);
    if (ox) begin
      void'(q.pop_front());
      n_frames++;
    end
    if (ix) begin
      n_accepted++;
      part.push_back(in_data);
      if (part.size() == N || in_last) model_close();
    end
    #1;
    $display("cyc in_v=%0b in_d=%02h last=%0b acc=%0b | frm_v=%0b frm_r=%0b out=%0b data=%08h cnt=%0d",
             in_valid, in_data, in_last, ix, exp_v, frm_ready, ox, frm_data, frm_count);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int stalls;
    int vcyc;
    int f0;
    int acc0;
    logic [DW-1:0] nxt;

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; frm_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_frm_valid", 64'(frm_valid), 64'd0);
    chk("rst_frm_data", 64'(frm_data), 64'd0);
    chk("rst_frm_count", 64'(frm_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    model_reset();
    idle(2);

    // full frame
    frm_ready = 1'b1;
    send(8'h30, 1'b0);
    send(8'h10, 1'b0);
    send(8'h40, 1'b0);
    send(8'h20, 1'b0);
    chk("full_valid", 64'(frm_valid), 64'd1);
    chk("full_data", 64'(frm_data), 64'h20401030);
    chk("full_count", 64'(frm_count), 64'd4);
    idle(1);
    chk("full_one_cycle", 64'(frm_valid), 64'd0);
    idle(1);

    // short frame, then next sample lands in lane 0
    send(8'h05, 1'b0);
    send(8'h07, 1'b1);
    chk("short_data", 64'(frm_data), 64'hFFFF0705);
    chk("short_count", 64'(frm_count), 64'd2);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    chk("after_short_data", 64'(frm_data), 64'h44332211);
    idle(2);

    // in_last on the final lane is an ordinary full frame
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    chk("last_on_n1_count", 64'(frm_count), 64'd4);
    chk("last_on_n1_data", 64'(frm_data), 64'h04030201);
    idle(2);

    // backpressure: 12 offers with frm_ready low
    frm_ready = 1'b0;
    acc0 = n_accepted;
    nxt = 8'h00;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = nxt; in_last = 1'b0;
      if (in_ready) nxt = nxt + 8'd1;
      step();
      if (i >= 8) chk("bp_stall_data", 64'(frm_data), 64'h03020100);
    end
    chk("bp_accepted", 64'(n_accepted - acc0), 64'd8);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    frm_ready = 1'b1;
    f0 = n_frames;
    for (int i = 0; i < 64 && nxt != 8'h0C; i++) begin
      in_valid = 1'b1; in_data = nxt; in_last = 1'b0;
      if (q.size() < 2) nxt = nxt + 8'd1;
      step();
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 64'(n_accepted - acc0), 64'd12);
    idle(4);
    chk("bp_frames_out", 64'(n_frames - f0), 64'd3);

    // sustained streaming
    stalls = 0; vcyc = 0; f0 = n_frames;
    for (int i = 0; i < 64; i++) begin
      if (!in_ready) stalls++;
      if (frm_valid) vcyc++;
      send(8'(i * 7 + 3), 1'b0);
    end
    if (frm_valid) vcyc++;
    idle(1);
    chk("sus_stalls", 64'(stalls), 64'd0);
    chk("sus_frames", 64'(n_frames - f0), 64'd16);
    chk("sus_valid_cycles", 64'(vcyc), 64'd16);
    idle(1);

    // reset mid-operation
    frm_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), 1'b0);
    chk("pre_rst_valid", 64'(frm_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(frm_valid), 64'd0);
    chk("mid_rst_data", 64'(frm_data), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frm_ready = 1'b1;
    send(8'h51, 1'b0);
    send(8'h52, 1'b0);
    send(8'h53, 1'b0);
    send(8'h54, 1'b0);
    chk("post_rst_count", 64'(frm_count), 64'd4);
    chk("post_rst_data", 64'(frm_data), 64'h54535251);
    idle(2);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      frm_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0;
    frm_ready = 1'b1;
    idle(4);
    chk("rand_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
